// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//
// Arbitrates NUM_M SRAM-like masters onto one SRAM-like slave. A round-robin
// winner is latched in IDLE, its request is presented to the slave in ADDR, and
// accepted masters are queued in an order FIFO so returned data is routed back
// to the master that issued the oldest outstanding transaction.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m_req/m_wr               per-master request and write flag
//   m_size/m_addr/m_wdata    per-master size, address and write data (slice i = master i)
//   m_addr_ok/m_data_ok      per-master address-accepted / data-returned pulses
//   m_rdata                  read data broadcast to all masters
//   s_req/s_wr/s_size/s_addr/s_wdata  slave request fields
//   s_addr_ok/s_data_ok/s_rdata       slave responses
//   outstanding              accepted transactions awaiting data
//   err                      sticky protocol error (abandoned request or stray data_ok)
module sram_like_arbiter #(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M-1:0]           m_req,
  input  logic [NUM_M-1:0]           m_wr,
  input  logic [2*NUM_M-1:0]         m_size,
  input  logic [ADDR_W*NUM_M-1:0]    m_addr,
  input  logic [DATA_W*NUM_M-1:0]    m_wdata,
  output logic [NUM_M-1:0]           m_addr_ok,
  output logic [NUM_M-1:0]           m_data_ok,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       s_req,
  output logic                       s_wr,
  output logic [1:0]                 s_size,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic                       s_addr_ok,
  input  logic                       s_data_ok,
  input  logic [DATA_W-1:0]          s_rdata,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err
);

  localparam int unsigned IdxW = $clog2(NUM_M);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StAddr} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [IdxW-1:0]   fifo_q [DEPTH];

  logic              win_valid;
  logic [IdxW-1:0]   win_idx;
  logic              full;
  logic              push, pop, abort, spurious;
  logic [IdxW-1:0]   head;
  int unsigned       g;

  assign full     = (count_q == CntW'(DEPTH));
  assign head     = fifo_q[rd_ptr_q];
  assign pop      = s_data_ok && (count_q != '0);
  assign spurious = s_data_ok && (count_q == '0);
  assign g        = 32'(grant_q);

  // First requester at or above rr_ptr, wrapping modulo NUM_M.
  always_comb begin
    int unsigned sum;
    logic [IdxW-1:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    sum       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      sum  = 32'(rr_ptr_q) + k;
      cand = IdxW'(sum % NUM_M);
      if (!win_valid && m_req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    push      = 1'b0;
    abort     = 1'b0;
    m_addr_ok = '0;
    s_req     = 1'b0;
    s_wr      = 1'b0;
    s_size    = '0;
    s_addr    = '0;
    s_wdata   = '0;
    unique case (state_q)
      StIdle: begin
        // Full check uses the registered count: a same-cycle pop does not free a slot.
        if (win_valid && !full) begin
          grant_d = win_idx;
          state_d = StAddr;
        end
      end
      StAddr: begin
        s_req   = 1'b1;
        s_wr    = m_wr[grant_q];
        s_size  = m_size[2*g +: 2];
        s_addr  = m_addr[g*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[g*DATA_W +: DATA_W];
        if (!m_req[grant_q]) begin
          // Master withdrew before acceptance: drop it and flag the violation.
          abort   = 1'b1;
          state_d = StIdle;
        end else if (s_addr_ok) begin
          m_addr_ok[grant_q] = 1'b1;
          push     = 1'b1;
          rr_ptr_d = (g == NUM_M - 1) ? '0 : grant_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_data_ok = '0;
    if (pop) m_data_ok[head] = 1'b1;
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign err_d       = err_q | abort | spurious;
  assign m_rdata     = s_rdata;
  assign outstanding = count_q;
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (order queue, busy master, rr pointer).
module tb_sram_like_arbiter;
  localparam int NUM_M  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_M-1:0]        m_req = '0, m_wr = '0;
  logic [2*NUM_M-1:0]      m_size = '0;
  logic [ADDR_W*NUM_M-1:0] m_addr = '0;
  logic [DATA_W*NUM_M-1:0] m_wdata = '0;
  logic [NUM_M-1:0]        m_addr_ok, m_data_ok;
  logic [DATA_W-1:0]       m_rdata;
  logic                    s_req, s_wr;
  logic [1:0]              s_size;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic                    s_addr_ok = 1'b0, s_data_ok = 1'b0;
  logic [DATA_W-1:0]       s_rdata = '0;
  logic [$clog2(DEPTH):0]  outstanding;
  logic                    err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit mdl_busy;
  int mdl_grant;
  int mdl_rr;
  int mdl_q[$];
  bit mdl_err;

  always #5 clk = ~clk;

  sram_like_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_busy = 0; mdl_grant = 0; mdl_rr = 0; mdl_q.delete(); mdl_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_edge();
    int size_before;
    size_before = mdl_q.size();
    if (s_data_ok) begin
      if (size_before > 0) void'(mdl_q.pop_front());
      else mdl_err = 1;
    end
    if (mdl_busy) begin
      if (!m_req[mdl_grant]) begin
        mdl_busy = 0;
        mdl_err  = 1;
      end else if (s_addr_ok) begin
        mdl_q.push_back(mdl_grant);
        mdl_rr   = (mdl_grant + 1) % NUM_M;
        mdl_busy = 0;
      end
    end else if (m_req != '0 && size_before < DEPTH) begin
      for (int k = 0; k < NUM_M; k++) begin
        if (m_req[(mdl_rr + k) % NUM_M]) begin
          mdl_grant = (mdl_rr + k) % NUM_M;
          break;
        end
      end
      mdl_busy = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_req = '1; s_data_ok = 1'b1; s_addr_ok = 1'b1;
    #3;
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL reset_s_req: got %0b want 0", s_req); end
    n_checks++; if (m_addr_ok !== '0) begin n_errors++; $display("FAIL reset_addr_ok: got %b want 00", m_addr_ok); end
    n_checks++; if (m_data_ok !== '0) begin n_errors++; $display("FAIL reset_data_ok: got %b want 00", m_data_ok); end
    n_checks++; if (outstanding !== '0) begin n_errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b want 0", err); end
    @(posedge clk); #2;
    n_checks++; if (s_req !== 1'b0 || s_addr !== '0) begin n_errors++; $display("FAIL reset_hold: s_req=%0b s_addr=%h want 0/0", s_req, s_addr); end
  endtask

  task automatic test_single_read();
    do_reset();
    m_req = 2'b01; m_addr[31:0] = 32'h1000; m_wr = 2'b00; s_addr_ok = 1'b1;
    @(negedge clk);
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL single_c0_s_req: got %0b want 0", s_req); end
    tick();
    @(negedge clk);
    n_checks++; if (s_req !== 1'b1) begin n_errors++; $display("FAIL single_c1_s_req: got %0b want 1", s_req); end
    n_checks++; if (s_addr !== 32'h1000) begin n_errors++; $display("FAIL single_c1_s_addr: got %h want 1000", s_addr); end
    n_checks++; if (s_wr !== 1'b0) begin n_errors++; $display("FAIL single_c1_s_wr: got %0b want 0", s_wr); end
    n_checks++; if (m_addr_ok !== 2'b01) begin n_errors++; $display("FAIL single_c1_addr_ok: got %b want 01", m_addr_ok); end
    tick();
    m_req = 2'b00;
    @(negedge clk);
    n_checks++; if (s_req !== 1'b0 || s_addr !== '0) begin n_errors++; $display("FAIL single_c2_idle: s_req=%0b s_addr=%h want 0/0", s_req, s_addr); end
    tick();
    s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++; if (m_data_ok !== 2'b01) begin n_errors++; $display("FAIL single_c3_data_ok: got %b want 01", m_data_ok); end
    n_checks++; if (m_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_c3_rdata: got %h want deadbeef", m_rdata); end
    tick();
    s_data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 0 || err !== 1'b0) begin n_errors++; $display("FAIL single_end: outstanding=%0d err=%0b want 0/0", outstanding, err); end
  endtask

  task automatic test_alternate();
    int hs_cyc[$];
    int hs_gnt[$];
    do_reset();
    m_req = 2'b11; s_addr_ok = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (m_addr_ok != '0) begin
        hs_cyc.push_back(c);
        hs_gnt.push_back(m_addr_ok == 2'b10 ? 1 : 0);
      end
      tick();
    end
    n_checks++; if (hs_cyc.size() !== 4) begin n_errors++; $display("FAIL alt_count: got %0d want 4", hs_cyc.size()); end
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++) begin
      n_checks++;
      if (hs_gnt[i] !== i % 2 || hs_cyc[i] !== 2 * i + 1) begin
        n_errors++;
        $display("FAIL alt_hs%0d: grant=%0d cycle=%0d want %0d/%0d", i, hs_gnt[i], hs_cyc[i], i % 2, 2 * i + 1);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    m_req = 2'b01; s_addr_ok = 1'b1;
    repeat (8) tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (outstanding !== 4 || s_req !== 1'b0) begin n_errors++; $display("FAIL full_hold%0d: outstanding=%0d s_req=%0b want 4/0", c, outstanding, s_req); end
      tick();
    end
    s_data_ok = 1'b1; s_rdata = 32'h5;
    @(negedge clk);
    n_checks++; if (m_data_ok !== 2'b01 || s_req !== 1'b0) begin n_errors++; $display("FAIL full_pop: data_ok=%b s_req=%0b want 01/0", m_data_ok, s_req); end
    tick();
    s_data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 3 || s_req !== 1'b0) begin n_errors++; $display("FAIL full_after_pop: outstanding=%0d s_req=%0b want 3/0", outstanding, s_req); end
    tick();
    @(negedge clk);
    n_checks++; if (s_req !== 1'b1) begin n_errors++; $display("FAIL full_regrant: s_req=%0b want 1", s_req); end
  endtask

  task automatic test_order();
    do_reset();
    m_req = 2'b10; s_addr_ok = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (m_addr_ok !== 2'b10) begin n_errors++; $display("FAIL order_hs1: got %b want 10", m_addr_ok); end
    tick();
    m_req = 2'b01;
    tick();
    @(negedge clk);
    n_checks++; if (m_addr_ok !== 2'b01) begin n_errors++; $display("FAIL order_hs0: got %b want 01", m_addr_ok); end
    tick();
    m_req = 2'b00; s_data_ok = 1'b1; s_rdata = 32'hA1;
    @(negedge clk);
    n_checks++; if (m_data_ok !== 2'b10) begin n_errors++; $display("FAIL order_first: got %b want 10", m_data_ok); end
    tick();
    s_rdata = 32'hB2;
    @(negedge clk);
    n_checks++; if (m_data_ok !== 2'b01 || m_rdata !== 32'hB2) begin n_errors++; $display("FAIL order_second: got %b/%h want 01/b2", m_data_ok, m_rdata); end
    tick();
    s_data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if (outstanding !== 0 || err !== 1'b0) begin n_errors++; $display("FAIL order_end: outstanding=%0d err=%0b want 0/0", outstanding, err); end
  endtask

  task automatic test_spurious();
    do_reset();
    s_data_ok = 1'b1;
    @(negedge clk);
    n_checks++; if (m_data_ok !== 2'b00) begin n_errors++; $display("FAIL spur_pulse: got %b want 00", m_data_ok); end
    tick();
    s_data_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL spur_err%0d: got %0b want 1", c, err); end
      tick();
    end
  endtask

  task automatic test_abort();
    do_reset();
    m_req = 2'b01; s_addr_ok = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (s_req !== 1'b1) begin n_errors++; $display("FAIL abort_s_req: got %0b want 1", s_req); end
    tick();
    m_req = 2'b00; s_addr_ok = 1'b1;
    @(negedge clk);
    n_checks++; if (m_addr_ok !== 2'b00) begin n_errors++; $display("FAIL abort_addr_ok: got %b want 00", m_addr_ok); end
    tick();
    @(negedge clk);
    n_checks++; if (s_req !== 1'b0 || err !== 1'b1 || outstanding !== 0) begin n_errors++; $display("FAIL abort_end: s_req=%0b err=%0b outstanding=%0d want 0/1/0", s_req, err, outstanding); end
  endtask

  task automatic test_async_reset();
    do_reset();
    s_data_ok = 1'b1;
    tick();
    s_data_ok = 1'b0; m_req = 2'b01; s_addr_ok = 1'b1;
    repeat (4) tick();
    s_addr_ok = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (outstanding !== 2 || s_req !== 1'b1 || err !== 1'b1) begin n_errors++; $display("FAIL arst_pre: outstanding=%0d s_req=%0b err=%0b want 2/1/1", outstanding, s_req, err); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (outstanding !== 0 || s_req !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL arst_now: outstanding=%0d s_req=%0b err=%0b want 0/0/0", outstanding, s_req, err); end
    #1 rst = 1'b0;
    m_req = 2'b00;
    tick();
    s_data_ok = 1'b1;
    @(negedge clk);
    n_checks++; if (m_data_ok !== 2'b00) begin n_errors++; $display("FAIL arst_stale_pulse: got %b want 00", m_data_ok); end
    tick();
    s_data_ok = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL arst_stale_err: got %0b want 1", err); end
  endtask

  task automatic test_random();
    logic [NUM_M-1:0]  e_aok, e_dok;
    logic              e_wr;
    logic [1:0]        e_size;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int i = 0; i < NUM_M; i++) if ($urandom_range(0, 4) == 0) m_req[i] = ~m_req[i];
      m_wr      = 2'($urandom);
      m_size    = 4'($urandom);
      m_addr    = {$urandom, $urandom};
      m_wdata   = {$urandom, $urandom};
      s_addr_ok = ($urandom_range(0, 2) != 0);
      s_data_ok = ($urandom_range(0, 2) == 0);
      s_rdata   = $urandom;
      @(negedge clk);
      e_aok = '0; e_dok = '0; e_wr = 1'b0; e_size = '0; e_addr = '0; e_wdata = '0;
      if (mdl_busy) begin
        e_wr    = m_wr[mdl_grant];
        e_size  = m_size[2*mdl_grant +: 2];
        e_addr  = m_addr[mdl_grant*ADDR_W +: ADDR_W];
        e_wdata = m_wdata[mdl_grant*DATA_W +: DATA_W];
        if (m_req[mdl_grant] && s_addr_ok) e_aok[mdl_grant] = 1'b1;
      end
      if (s_data_ok && mdl_q.size() > 0) e_dok[mdl_q[0]] = 1'b1;
      n_checks++;
      if (s_req !== mdl_busy || s_wr !== e_wr || s_size !== e_size || s_addr !== e_addr || s_wdata !== e_wdata) begin
        n_errors++;
        $display("FAIL rand_slave c%0d: req=%0b wr=%0b size=%0d addr=%h wdata=%h want %0b/%0b/%0d/%h/%h",
                 c, s_req, s_wr, s_size, s_addr, s_wdata, mdl_busy, e_wr, e_size, e_addr, e_wdata);
      end
      n_checks++;
      if (m_addr_ok !== e_aok || m_data_ok !== e_dok || m_rdata !== s_rdata) begin
        n_errors++;
        $display("FAIL rand_master c%0d: addr_ok=%b data_ok=%b rdata=%h want %b/%b/%h",
                 c, m_addr_ok, m_data_ok, m_rdata, e_aok, e_dok, s_rdata);
      end
      n_checks++;
      if (outstanding !== mdl_q.size() || err !== mdl_err) begin
        n_errors++;
        $display("FAIL rand_status c%0d: outstanding=%0d err=%0b want %0d/%0b", c, outstanding, err, mdl_q.size(), mdl_err);
      end
      model_edge();
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_full();
    test_order();
    test_spurious();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
